// File: rtl/vlb_lkp.sv
// rtl/vlb_lkp.sv - fully-associative lookaside buffer in front of the FST translation engine
// One outstanding miss at a time; the victim entry index doubles as the FST request tag.
module vlb_lkp #(
  parameter int N_ENT    = 16,
  parameter int VPN_W    = 52,
  parameter int MPN_W    = 52,
  parameter int IDX_W    = 6,
  parameter int IDX_BASE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lkp_i_valid,
  input  logic [VPN_W-1:0] lkp_i_vpn,
  output logic             lkp_o_ready,
  output logic             lkp_o_valid,
  output logic             lkp_o_hit,
  output logic             lkp_o_err,
  output logic [MPN_W-1:0] lkp_o_mpn,
  output logic [3:0]       lkp_o_attr,
  input  logic             flush_i,
  output logic             req_o_valid,
  output logic [IDX_W-1:0] req_o_bits_idx,
  output logic [VPN_W-1:0] req_o_bits_vpn,
  input  logic             resp_i_valid,
  input  logic [IDX_W-1:0] resp_i_idx,
  input  logic             resp_i_vld,
  input  logic             resp_i_err,
  input  logic [MPN_W-1:0] resp_i_mpn,
  input  logic [3:0]       resp_i_attr,
  input  logic             fill_i_valid,
  input  logic [IDX_W-1:0] fill_i_idx,
  input  logic             fill_i_vld,
  input  logic             fill_i_err,
  input  logic [MPN_W-1:0] fill_i_mpn,
  input  logic [3:0]       fill_i_attr,
  output logic [1:0]       kill_o,
  input  logic             busy_i
);
  localparam int PTR_W = $clog2(N_ENT);

  typedef enum logic [1:0] {IDLE, PEND, WAIT, DRAIN} state_t;
  state_t state, state_nxt;

  logic             up;
  logic [N_ENT-1:0] ent_vld;
  logic [N_ENT-1:0] ent_err;
  logic [VPN_W-1:0] ent_vpn  [N_ENT];
  logic [MPN_W-1:0] ent_mpn  [N_ENT];
  logic [3:0]       ent_attr [N_ENT];

  logic [PTR_W-1:0] rr_ptr, vic, vic_nxt;
  logic             vic_rr, vic_rr_nxt;
  logic [VPN_W-1:0] miss_vpn;
  logic [IDX_W-1:0] tag;

  logic             accept, hit, hit_err;
  logic [MPN_W-1:0] hit_mpn;
  logic [3:0]       hit_attr;
  logic             resp_take, fill_take, use_fill, wr_en;
  logic             wr_err;
  logic [MPN_W-1:0] wr_mpn;
  logic [3:0]       wr_attr;

  assign tag         = IDX_W'(IDX_BASE) | IDX_W'(vic);
  assign lkp_o_ready = up & (state == IDLE) & ~flush_i;
  assign accept      = lkp_i_valid & lkp_o_ready;

  assign req_o_bits_idx = req_o_valid ? tag : '0;
  assign req_o_bits_vpn = req_o_valid ? miss_vpn : '0;

  // VPNs never duplicate, so OR-reducing the matching entries selects exactly one.
  always_comb begin
    hit      = 1'b0;
    hit_err  = 1'b0;
    hit_mpn  = '0;
    hit_attr = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (ent_vld[i] && (ent_vpn[i] == lkp_i_vpn)) begin
        hit      = 1'b1;
        hit_err  = hit_err | ent_err[i];
        hit_mpn  = hit_mpn | ent_mpn[i];
        hit_attr = hit_attr | ent_attr[i];
      end
    end
  end

  always_comb begin
    vic_nxt    = rr_ptr;
    vic_rr_nxt = 1'b1;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        vic_nxt    = PTR_W'(i);
        vic_rr_nxt = 1'b0;
      end
    end
  end

  // A resp with vld=0 only announces a later fill; a simultaneous valid fill takes precedence.
  always_comb begin
    resp_take = resp_i_valid & resp_i_vld & (resp_i_idx == tag);
    fill_take = fill_i_valid & (fill_i_idx == tag);
    use_fill  = fill_take & (fill_i_vld | ~resp_take);
    wr_en     = (state == WAIT) & ~flush_i & (resp_take | fill_take);
    wr_err    = use_fill ? fill_i_err  : resp_i_err;
    wr_mpn    = use_fill ? fill_i_mpn  : resp_i_mpn;
    wr_attr   = use_fill ? fill_i_attr : resp_i_attr;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !hit) state_nxt = PEND;
      PEND:    if (flush_i) state_nxt = IDLE;
               else if (!busy_i) state_nxt = WAIT;
      WAIT:    if (flush_i) state_nxt = DRAIN;
               else if (resp_take || fill_take) state_nxt = IDLE;
      DRAIN:   if (!busy_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      up          <= 1'b0;
      ent_vld     <= '0;
      rr_ptr      <= '0;
      vic         <= '0;
      vic_rr      <= 1'b0;
      miss_vpn    <= '0;
      req_o_valid <= 1'b0;
      kill_o      <= '0;
      lkp_o_valid <= 1'b0;
      lkp_o_hit   <= 1'b0;
      lkp_o_err   <= 1'b0;
      lkp_o_mpn   <= '0;
      lkp_o_attr  <= '0;
    end else begin
      state       <= state_nxt;
      up          <= 1'b1;
      lkp_o_valid <= accept;
      if (accept) begin
        lkp_o_hit  <= hit;
        lkp_o_err  <= hit_err;
        lkp_o_mpn  <= hit_mpn;
        lkp_o_attr <= hit_attr;
      end
      if (accept && !hit) begin
        vic      <= vic_nxt;
        vic_rr   <= vic_rr_nxt;
        miss_vpn <= lkp_i_vpn;
      end
      req_o_valid <= (state == PEND) & ~busy_i & ~flush_i;
      kill_o      <= {flush_i & (state == WAIT), flush_i};
      if (flush_i) ent_vld <= '0;
      else if (wr_en) ent_vld[vic] <= 1'b1;
      if (wr_en && vic_rr) rr_ptr <= rr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      ent_vpn[vic]  <= miss_vpn;
      ent_mpn[vic]  <= wr_mpn;
      ent_err[vic]  <= wr_err;
      ent_attr[vic] <= wr_attr;
    end
  end
endmodule

// File: tb/tb_vlb_lkp.sv
// tb/tb_vlb_lkp.sv - scoreboard bench for vlb_lkp with IDX_BASE 0x00 and 0x20 instances
module tb_vlb_lkp;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        lv [2], rdy [2], ov [2], ohit [2], oerr [2], flush [2], rqv [2], busy [2];
  logic [51:0] lvpn [2], ompn [2], rqvpn [2], rsmpn [2], flmpn [2];
  logic [3:0]  oattr [2], rsattr [2], flattr [2];
  logic [5:0]  rqidx [2], rsidx [2], flidx [2];
  logic        rsv [2], rsvld [2], rserr [2], flv [2], flvld [2], flerr [2];
  logic [1:0]  kill [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vlb_lkp #(.N_ENT(16), .VPN_W(52), .MPN_W(52), .IDX_W(6), .IDX_BASE(g * 32)) u_dut (
      .clock(clock), .reset(reset),
      .lkp_i_valid(lv[g]), .lkp_i_vpn(lvpn[g]), .lkp_o_ready(rdy[g]),
      .lkp_o_valid(ov[g]), .lkp_o_hit(ohit[g]), .lkp_o_err(oerr[g]),
      .lkp_o_mpn(ompn[g]), .lkp_o_attr(oattr[g]), .flush_i(flush[g]),
      .req_o_valid(rqv[g]), .req_o_bits_idx(rqidx[g]), .req_o_bits_vpn(rqvpn[g]),
      .resp_i_valid(rsv[g]), .resp_i_idx(rsidx[g]), .resp_i_vld(rsvld[g]),
      .resp_i_err(rserr[g]), .resp_i_mpn(rsmpn[g]), .resp_i_attr(rsattr[g]),
      .fill_i_valid(flv[g]), .fill_i_idx(flidx[g]), .fill_i_vld(flvld[g]),
      .fill_i_err(flerr[g]), .fill_i_mpn(flmpn[g]), .fill_i_attr(flattr[g]),
      .kill_o(kill[g]), .busy_i(busy[g])
    );
  end

  typedef struct packed {logic hit; logic err; logic [51:0] mpn; logic [3:0] attr;} lkp_t;
  typedef struct packed {logic [5:0] idx; logic [51:0] vpn;} req_t;
  lkp_t lq0[$], lq1[$];
  req_t rq0[$], rq1[$];
  lkp_t le;
  req_t re;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (ov[d]) begin
          if ((d == 0 ? lq0.size() : lq1.size()) == 0) check_val("lkp_unexpected", 64'(ov[d]), 64'd0);
          else begin
            if (d == 0) le = lq0.pop_front(); else le = lq1.pop_front();
            check_val("lkp_hit", 64'(ohit[d]), 64'(le.hit));
            check_val("lkp_err", 64'(oerr[d]), 64'(le.err));
            check_val("lkp_mpn", 64'(ompn[d]), 64'(le.mpn));
            check_val("lkp_attr", 64'(oattr[d]), 64'(le.attr));
          end
        end
        if (rqv[d]) begin
          if ((d == 0 ? rq0.size() : rq1.size()) == 0) check_val("req_unexpected", 64'(rqv[d]), 64'd0);
          else begin
            if (d == 0) re = rq0.pop_front(); else re = rq1.pop_front();
            check_val("req_idx", 64'(rqidx[d]), 64'(re.idx));
            check_val("req_vpn", 64'(rqvpn[d]), 64'(re.vpn));
          end
        end
      end
    end
  end

  task automatic lookup(input int d, input logic [51:0] vpn, input logic h, input logic e,
                        input logic [51:0] m, input logic [3:0] a, input logic [5:0] tag);
    int n = 0;
    lkp_t x;
    req_t r;
    while (rdy[d] !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) check_val("lkp_ready_timeout", 64'(rdy[d]), 64'd1);
    lv[d] = 1'b1;
    lvpn[d] = vpn;
    x = '{hit: h, err: e, mpn: m, attr: a};
    r = '{idx: tag, vpn: vpn};
    if (d == 0) lq0.push_back(x); else lq1.push_back(x);
    if (!h) begin
      if (d == 0) rq0.push_back(r); else rq1.push_back(r);
    end
    @(negedge clock);
    lv[d] = 1'b0;
  endtask

  task automatic wait_req(input int d);
    int n = 0;
    while (rqv[d] !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) check_val("req_timeout", 64'(rqv[d]), 64'd1);
  endtask

  task automatic send(input int d, input bit is_fill, input logic [5:0] idx, input logic vld,
                      input logic err, input logic [51:0] mpn, input logic [3:0] attr);
    if (is_fill) begin
      flv[d] = 1'b1; flidx[d] = idx; flvld[d] = vld; flerr[d] = err; flmpn[d] = mpn; flattr[d] = attr;
    end else begin
      rsv[d] = 1'b1; rsidx[d] = idx; rsvld[d] = vld; rserr[d] = err; rsmpn[d] = mpn; rsattr[d] = attr;
    end
    @(negedge clock);
    flv[d] = 1'b0;
    rsv[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      lv[d] = 0; lvpn[d] = '0; flush[d] = 0; busy[d] = 0;
      rsv[d] = 0; rsidx[d] = '0; rsvld[d] = 0; rserr[d] = 0; rsmpn[d] = '0; rsattr[d] = '0;
      flv[d] = 0; flidx[d] = '0; flvld[d] = 0; flerr[d] = 0; flmpn[d] = '0; flattr[d] = '0;
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check_val("rst_ready", 64'(rdy[d]), 64'd0);
      check_val("rst_lkp_valid", 64'(ov[d]), 64'd0);
      check_val("rst_req_valid", 64'(rqv[d]), 64'd0);
      check_val("rst_kill", 64'(kill[d]), 64'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    check_val("ready_after_rst", 64'(rdy[0]), 64'd1);

    // flush in IDLE blocks a coincident lookup and pulses kill[0] only
    flush[0] = 1'b1; lv[0] = 1'b1; lvpn[0] = 52'h55;
    #1 check_val("flush_ready", 64'(rdy[0]), 64'd0);
    @(negedge clock);
    flush[0] = 1'b0; lv[0] = 1'b0;
    check_val("kill_idle", 64'(kill[0]), 64'd1);
    check_val("flush_lkp_drop", 64'(ov[0]), 64'd0);
    @(negedge clock);
    check_val("kill_idle_end", 64'(kill[0]), 64'd0);

    // cold miss then hit
    lookup(0, 52'h123, 0, 0, 52'h0, 4'h0, 6'h00);
    wait_req(0);
    send(0, 0, 6'h00, 1, 0, 52'h456, 4'hF);
    lookup(0, 52'h123, 1, 0, 52'h456, 4'hF, 6'h00);

    // IDX_BASE=0x20 instance: vld=0 resp, foreign fill, then real fill with err
    lookup(1, 52'h777, 0, 0, 52'h0, 4'h0, 6'h20);
    wait_req(1);
    send(1, 0, 6'h20, 0, 0, 52'h0, 4'h0);
    check_val("resp_vld0_ready", 64'(rdy[1]), 64'd0);
    send(1, 1, 6'h21, 1, 0, 52'h999, 4'h1);
    check_val("foreign_fill_ready", 64'(rdy[1]), 64'd0);
    send(1, 1, 6'h20, 0, 1, 52'hABC, 4'h3);
    lookup(1, 52'h777, 1, 1, 52'hABC, 4'h3, 6'h20);

    // busy holds off the request
    busy[0] = 1'b1;
    lookup(0, 52'h200, 0, 0, 52'h0, 4'h0, 6'h01);
    for (int i = 0; i < 5; i++) begin
      check_val("busy_no_req", 64'(rqv[0]), 64'd0);
      @(negedge clock);
    end
    busy[0] = 1'b0;
    @(negedge clock);
    check_val("busy_fall_req", 64'(rqv[0]), 64'd1);
    send(0, 0, 6'h01, 1, 0, 52'h201, 4'h1);

    // fill entries 2..15, then the 17th VPN replaces entry 0
    for (int i = 0; i < 14; i++) begin
      lookup(0, 52'h1000 + 52'(i), 0, 0, 52'h0, 4'h0, 6'(i + 2));
      wait_req(0);
      send(0, 0, 6'(i + 2), 1, 0, 52'h2000 + 52'(i), 4'(i));
    end
    lookup(0, 52'h1000, 1, 0, 52'h2000, 4'h0, 6'h00);
    lookup(0, 52'h5000, 0, 0, 52'h0, 4'h0, 6'h00);
    wait_req(0);
    send(0, 0, 6'h00, 1, 0, 52'h5001, 4'h5);
    lookup(0, 52'h5000, 1, 0, 52'h5001, 4'h5, 6'h00);
    lookup(0, 52'h123, 0, 0, 52'h0, 4'h0, 6'h01);
    wait_req(0);

    // flush in WAIT: both kills, DRAIN ignores the stale fill until busy drops
    busy[0] = 1'b1; flush[0] = 1'b1;
    @(negedge clock);
    flush[0] = 1'b0;
    check_val("kill_wait", 64'(kill[0]), 64'd3);
    check_val("drain_ready", 64'(rdy[0]), 64'd0);
    send(0, 1, 6'h01, 1, 0, 52'h999, 4'h9);
    check_val("kill_wait_end", 64'(kill[0]), 64'd0);
    check_val("drain_busy_ready", 64'(rdy[0]), 64'd0);
    busy[0] = 1'b0;
    @(negedge clock);
    check_val("drain_exit_ready", 64'(rdy[0]), 64'd1);
    lookup(0, 52'h123, 0, 0, 52'h0, 4'h0, 6'h00);
    wait_req(0);

    // flush coincident with a matching resp: nothing written
    flush[0] = 1'b1;
    rsv[0] = 1'b1; rsidx[0] = 6'h00; rsvld[0] = 1'b1; rserr[0] = 1'b0; rsmpn[0] = 52'h77; rsattr[0] = 4'h7;
    @(negedge clock);
    flush[0] = 1'b0; rsv[0] = 1'b0;
    check_val("kill_coinc", 64'(kill[0]), 64'd3);
    check_val("coinc_drain_ready", 64'(rdy[0]), 64'd0);
    @(negedge clock);
    check_val("coinc_idle_ready", 64'(rdy[0]), 64'd1);
    lookup(0, 52'h123, 0, 0, 52'h0, 4'h0, 6'h00);
    wait_req(0);
    send(0, 0, 6'h00, 1, 0, 52'h88, 4'h2);
    lookup(0, 52'h123, 1, 0, 52'h88, 4'h2, 6'h00);

    repeat (3) @(negedge clock);
    check_val("lkp_q0_empty", 64'(lq0.size()), 64'd0);
    check_val("lkp_q1_empty", 64'(lq1.size()), 64'd0);
    check_val("req_q0_empty", 64'(rq0.size()), 64'd0);
    check_val("req_q1_empty", 64'(rq1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
